// File: rtl/mac_rx_fetch_ctrl.sv
// Receive fetch sequencer: pulls one frame at a time from the MAC client FIFO
// into a circular word buffer and publishes a (start, byte length) descriptor
// for each good frame. Frames with bad framing or too many words are discarded
// and counted.
module mac_rx_fetch_ctrl #(
  parameter int ADDR_W    = 13,
  parameter int MAX_WORDS = 384
) (
  input  logic              mac_clk_i,
  input  logic              mac_rst_i,
  input  logic [31:0]       mac_rxd_i,
  input  logic [1:0]        mac_ben_i,
  input  logic              mac_rxda_i,
  input  logic              mac_rxsop_i,
  input  logic              mac_rxeop_i,
  input  logic              mac_rxdv_i,
  output logic              mac_rxrqrd_o,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_waddr_o,
  output logic [31:0]       buf_wdata_o,
  input  logic [ADDR_W-1:0] buf_rd_ptr_i,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ADDR_W-1:0] desc_start_o,
  output logic [10:0]       desc_len_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DROP, COMMIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cmt_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  wcnt;
  logic [ADDR_W-1:0] free_words;
  logic              space_ok;
  logic              bad_word;
  logic [2:0]        last_bytes;

  // One slot is always kept empty so full and empty are distinguishable.
  assign free_words = buf_rd_ptr_i - cmt_ptr - ADDR_W'(1);
  assign space_ok   = int'(free_words) >= MAX_WORDS;

  // Word 0 must carry sop, later words must not, and nothing past MAX_WORDS.
  assign bad_word = (wcnt == '0) ? !mac_rxsop_i
                                 : (mac_rxsop_i || (wcnt == CNT_W'(MAX_WORDS)));

  // ben 00 means a full word; otherwise ben is the byte count itself.
  assign last_bytes = {mac_ben_i == 2'b00, mac_ben_i};

  // Frame sequencer; every output is a register written here.
  always_ff @(posedge mac_clk_i or posedge mac_rst_i) begin
    if (mac_rst_i) begin
      state        <= IDLE;
      cmt_ptr      <= '0;
      wr_ptr       <= '0;
      wcnt         <= '0;
      mac_rxrqrd_o <= 1'b0;
      buf_we_o     <= 1'b0;
      buf_waddr_o  <= '0;
      buf_wdata_o  <= '0;
      desc_valid_o <= 1'b0;
      desc_start_o <= '0;
      desc_len_o   <= '0;
      drop_cnt_o   <= '0;
    end else begin
      buf_we_o <= 1'b0;
      case (state)
        IDLE: begin
          // Only start when a worst-case frame is guaranteed to fit.
          if (mac_rxda_i && space_ok) begin
            state        <= FETCH;
            mac_rxrqrd_o <= 1'b1;
            wr_ptr       <= cmt_ptr;
            wcnt         <= '0;
          end
        end
        FETCH: begin
          if (mac_rxdv_i) begin
            if (bad_word) begin
              // An error word carrying eop ends the discard right here.
              if (mac_rxeop_i) begin
                state        <= IDLE;
                mac_rxrqrd_o <= 1'b0;
                wr_ptr       <= cmt_ptr;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 16'd1;
              end else begin
                state <= DROP;
              end
            end else begin
              buf_we_o    <= 1'b1;
              buf_waddr_o <= wr_ptr;
              buf_wdata_o <= mac_rxd_i;
              wr_ptr      <= wr_ptr + ADDR_W'(1);
              wcnt        <= wcnt + CNT_W'(1);
              if (mac_rxeop_i) begin
                state        <= COMMIT;
                mac_rxrqrd_o <= 1'b0;
                desc_valid_o <= 1'b1;
                desc_start_o <= cmt_ptr;
                desc_len_o   <= 11'({wcnt, 2'b00}) + 11'(last_bytes);
              end
            end
          end
        end
        DROP: begin
          if (mac_rxdv_i && mac_rxeop_i) begin
            state        <= IDLE;
            mac_rxrqrd_o <= 1'b0;
            wr_ptr       <= cmt_ptr;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 16'd1;
          end
        end
        COMMIT: begin
          // Descriptor fields are left untouched until the handshake.
          if (desc_ready_i) begin
            state        <= IDLE;
            desc_valid_o <= 1'b0;
            cmt_ptr      <= wr_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_fetch_ctrl.sv
// Bench for mac_rx_fetch_ctrl: the bench plays MAC and consumer, keeps a
// frame-level model (committed pointer, free space, expected addresses,
// lengths and drop count) and checks the buffer writes and descriptors.
module tb_mac_rx_fetch_ctrl;
  localparam int AW   = 9;
  localparam int MAXW = 384;
  localparam int D    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   rxd = '0;
  logic [1:0]    ben = '0;
  logic          rxda = 1'b0, sop = 1'b0, eop = 1'b0, rxdv = 1'b0;
  logic          rxrqrd, buf_we;
  logic [AW-1:0] buf_waddr;
  logic [31:0]   buf_wdata;
  logic [AW-1:0] rd_ptr = '0;
  logic          desc_valid;
  logic          desc_ready = 1'b0;
  logic [AW-1:0] desc_start;
  logic [10:0]   desc_len;
  logic [15:0]   drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cmt   = 0;   // model committed pointer
  int drops = 0;   // model drop count
  bit saw_wrap = 1'b0;

  logic [31:0]   fr[$];
  logic [AW-1:0] wq_a[$];
  logic [31:0]   wq_d[$];

  always #5 clk = ~clk;

  mac_rx_fetch_ctrl #(.ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
    .mac_clk_i(clk), .mac_rst_i(rst), .mac_rxd_i(rxd), .mac_ben_i(ben),
    .mac_rxda_i(rxda), .mac_rxsop_i(sop), .mac_rxeop_i(eop), .mac_rxdv_i(rxdv),
    .mac_rxrqrd_o(rxrqrd), .buf_we_o(buf_we), .buf_waddr_o(buf_waddr),
    .buf_wdata_o(buf_wdata), .buf_rd_ptr_i(rd_ptr), .desc_valid_o(desc_valid),
    .desc_ready_i(desc_ready), .desc_start_o(desc_start), .desc_len_o(desc_len),
    .drop_cnt_o(drop_cnt)
  );

  // Record every buffer write seen on the port.
  always @(negedge clk)
    if (rst === 1'b0 && buf_we === 1'b1) begin
      wq_a.push_back(buf_waddr);
      wq_d.push_back(buf_wdata);
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] b);
    return (b == 2'b00) ? 4 : int'(b);
  endfunction

  function automatic int free_of(input int rd);
    return (((rd - cmt - 1) % D) + D) % D;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_rqrd", rxrqrd, 0);
    chk("rst_we", buf_we, 0);
    chk("rst_waddr", buf_waddr, 0);
    chk("rst_wdata", buf_wdata, 0);
    chk("rst_dvalid", desc_valid, 0);
    chk("rst_dstart", desc_start, 0);
    chk("rst_dlen", desc_len, 0);
    chk("rst_drop", drop_cnt, 0);
  endtask

  task automatic wait_rq();
    int t = 0;
    while (rxrqrd !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("rqrd_timeout", rxrqrd, 1);
  endtask

  // MAC side: one word per cycle, eop on the last word.
  task automatic drive(input int n, input bit nosop, input logic [1:0] b);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back($urandom);
    for (int i = 0; i < n; i++) begin
      rxdv = 1'b1;
      rxd  = fr[i];
      sop  = (i == 0) && !nosop;
      eop  = (i == n - 1);
      ben  = (i == n - 1) ? b : 2'($urandom);
      @(negedge clk);
    end
    rxdv = 1'b0; sop = 1'b0; eop = 1'b0; rxd = '0;
  endtask

  task automatic chk_writes(input int n, input int start);
    chk("nwrites", wq_a.size(), n);
    for (int i = 0; i < n && i < wq_a.size(); i++) begin
      chk("waddr", wq_a[i], (start + i) % D);
      chk("wdata", wq_d[i], fr[i]);
      if (i > 0 && wq_a[i-1] == AW'(D - 1) && wq_a[i] == '0) saw_wrap = 1'b1;
    end
  endtask

  task automatic good_frame(input int n, input logic [1:0] b, input int hold, input bit follow);
    int start = cmt;
    int len   = 4 * (n - 1) + nbytes(b);
    wq_a.delete(); wq_d.delete();
    wait_rq();
    drive(n, 1'b0, b);
    chk("dvalid_rise", desc_valid, 1);
    chk("rqrd_fall", rxrqrd, 0);
    chk("dstart", desc_start, start);
    chk("dlen", desc_len, len);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", desc_valid, 1);
      chk("hold_start", desc_start, start);
      chk("hold_len", desc_len, len);
      chk("hold_rqrd", rxrqrd, 0);
    end
    cmt = (cmt + n) % D;
    desc_ready = 1'b1;
    if (follow) rd_ptr = AW'(cmt);
    @(negedge clk);
    desc_ready = 1'b0;
    chk("dvalid_fall", desc_valid, 0);
    chk("rqrd_gap", rxrqrd, 0);
    chk_writes(n, start);
  endtask

  task automatic drop_frame(input int n, input bit nosop);
    int start = cmt;
    int nw = nosop ? 0 : ((n > MAXW) ? MAXW : n);
    wq_a.delete(); wq_d.delete();
    wait_rq();
    drive(n, nosop, 2'($urandom));
    chk("drop_novalid", desc_valid, 0);
    @(negedge clk);
    @(negedge clk);
    drops++;
    chk_writes(nw, start);
    chk("drop_cnt", drop_cnt, drops);
    chk("drop_novalid2", desc_valid, 0);
  endtask

  task automatic expect_blocked();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("blocked_rqrd", rxrqrd, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst  = 1'b0;
    rxda = 1'b1;

    // Basic 16-word frame from reset.
    good_frame(16, 2'b00, 0, 1'b1);
    // Back-to-back: partial last word, then a second frame right after.
    good_frame(16, 2'b01, 0, 1'b1);
    good_frame($urandom_range(2, 40), 2'($urandom), 0, 1'b1);
    chk("drop_zero", drop_cnt, 0);

    // Consumer stalls the descriptor for 10 cycles.
    good_frame($urandom_range(1, 60), 2'($urandom), 10, 1'b1);
    @(negedge clk);
    chk("resume_rqrd", rxrqrd, (free_of(int'(rd_ptr)) >= MAXW) ? 1 : 0);

    // Oversize frame then missing-sop frame.
    drop_frame(400, 1'b0);
    good_frame($urandom_range(1, 50), 2'($urandom), 0, 1'b1);
    drop_frame(5, 1'b1);

    // Length boundaries: exact max, one over, single word.
    good_frame(MAXW, 2'($urandom), 0, 1'b1);
    drop_frame(MAXW + 1, 1'b0);
    good_frame(1, 2'($urandom), 0, 1'b1);

    // Random traffic.
    for (int k = 0; k < 6; k++)
      good_frame($urandom_range(1, MAXW), 2'($urandom), $urandom_range(0, 3), 1'b1);
    chk("drop_total", drop_cnt, drops);

    // Reset in the middle of a frame (after word 5 is taken).
    wait_rq();
    for (int i = 0; i < 5; i++) begin
      rxdv = 1'b1; rxd = $urandom; sop = (i == 0); eop = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1; rxdv = 1'b0; sop = 1'b0; rd_ptr = '0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    cmt = 0; drops = 0;
    good_frame(20, 2'($urandom), 0, 1'b0);

    // Consumer parked at 0: fetching stops once space runs short.
    while (free_of(int'(rd_ptr)) >= MAXW) good_frame(100, 2'($urandom), 0, 1'b0);
    expect_blocked();
    // Consumer catches up; frames continue and wrap the buffer.
    for (int k = 0; k < 4; k++) begin
      if (free_of(int'(rd_ptr)) < MAXW) rd_ptr = AW'(cmt);
      good_frame(100, 2'($urandom), 0, 1'b0);
    end
    chk("wrap_seen", saw_wrap, 1);
    chk("drop_after_rst", drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
